// File: rtl/dvga_sprite_ovl_if.sv
// Register and sprite-RAM write bus for the sprite overlay.
// The master side drives configuration writes; the overlay consumes them.
interface dvga_sprite_ovl_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        spr_we;
  logic [7:0]  spr_addr;
  logic [1:0]  spr_wdata;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    output spr_we, spr_addr, spr_wdata
  );

  modport slave (
    input cfg_we, cfg_addr, cfg_wdata,
    input spr_we, spr_addr, spr_wdata
  );
endinterface

// File: rtl/dvga_sprite_ovl.sv
// 16x16 2-bit hardware sprite composited over a video stream.
// Pixel coordinates arrive three cycles ahead of their colour, so the sprite
// lookup runs in a 3-stage pipeline that lands next to r_i/g_i/b_i, followed
// by one output register. Position updates are latched on vsync rise.
`ifndef XCNTW
`define XCNTW 11
`endif
`ifndef YCNTW
`define YCNTW 11
`endif

module dvga_sprite_ovl (
  input  logic              clk,
  input  logic              rst,
  dvga_sprite_ovl_if.slave  bus,
  input  logic [`XCNTW-1:0] xpos_i,
  input  logic [`YCNTW-1:0] ypos_i,
  input  logic [7:0]        r_i,
  input  logic [7:0]        g_i,
  input  logic [7:0]        b_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              blank_i,
  output logic [7:0]        r_o,
  output logic [7:0]        g_o,
  output logic [7:0]        b_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              blank_o
);
  localparam int unsigned XW = `XCNTW;
  localparam int unsigned YW = `YCNTW;
  localparam logic [23:0] Pal3 = 24'hFFFFFF;

  // Configuration state
  logic          ctrl_en_q, ctrl_en_d;
  logic [XW-1:0] pos_pend_x_q, pos_pend_x_d;
  logic [YW-1:0] pos_pend_y_q, pos_pend_y_d;
  logic [XW-1:0] pos_act_x_q, pos_act_x_d;
  logic [YW-1:0] pos_act_y_q, pos_act_y_d;
  logic [23:0]   pal1_q, pal1_d;
  logic [23:0]   pal2_q, pal2_d;
  logic          vs_prev_q, vs_prev_d;

  // Pipeline state
  logic          hit1_q, hit1_d;
  logic [7:0]    addr1_q, addr1_d;
  logic          hit2_q, hit2_d;
  logic [1:0]    ram_rdata_q;
  logic          opq3_q, opq3_d;
  logic [23:0]   col3_q, col3_d;
  logic          blank1_q, blank1_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;

  logic [1:0]    spr_mem [256];

  // Compare operands carry one extra bit so sx+16 never wraps past the edge
  logic [XW:0]   x_ext, sx_lo, sx_hi;
  logic [YW:0]   y_ext, sy_lo, sy_hi;
  logic [3:0]    x_off, y_off;

  logic          unused_wdata;
  assign unused_wdata = ^bus.cfg_wdata;

  // Register writes and frame-synchronous position update
  always_comb begin
    ctrl_en_d    = ctrl_en_q;
    pos_pend_x_d = pos_pend_x_q;
    pos_pend_y_d = pos_pend_y_q;
    pal1_d       = pal1_q;
    pal2_d       = pal2_q;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        2'd0: ctrl_en_d = bus.cfg_wdata[0];
        2'd1: begin
          pos_pend_x_d = bus.cfg_wdata[XW-1:0];
          pos_pend_y_d = bus.cfg_wdata[16+YW-1:16];
        end
        2'd2: pal1_d = bus.cfg_wdata[23:0];
        default: pal2_d = bus.cfg_wdata[23:0];
      endcase
    end
    vs_prev_d   = vsync_i;
    pos_act_x_d = pos_act_x_q;
    pos_act_y_d = pos_act_y_q;
    if (vsync_i && !vs_prev_q) begin
      pos_act_x_d = pos_pend_x_q;
      pos_act_y_d = pos_pend_y_q;
    end
  end

  // Stage 1: window compare and sprite-local address
  always_comb begin
    x_ext   = {1'b0, xpos_i};
    y_ext   = {1'b0, ypos_i};
    sx_lo   = {1'b0, pos_act_x_q};
    sy_lo   = {1'b0, pos_act_y_q};
    sx_hi   = sx_lo + {{(XW-4){1'b0}}, 5'd16};
    sy_hi   = sy_lo + {{(YW-4){1'b0}}, 5'd16};
    hit1_d  = (x_ext >= sx_lo) && (x_ext < sx_hi) && (y_ext >= sy_lo) && (y_ext < sy_hi);
    x_off   = xpos_i[3:0] - pos_act_x_q[3:0];
    y_off   = ypos_i[3:0] - pos_act_y_q[3:0];
    addr1_d = {y_off, x_off};
  end

  // Stages 2-3 and output: hit delay, palette lookup, final composite
  always_comb begin
    hit2_d = hit1_q;
    opq3_d = ctrl_en_q && hit2_q && (ram_rdata_q != 2'd0);
    case (ram_rdata_q)
      2'd1:    col3_d = pal1_q;
      2'd2:    col3_d = pal2_q;
      default: col3_d = Pal3;
    endcase
    blank1_d = blank_i;
    rgb_d    = (opq3_q && !blank1_q) ? col3_q : {r_i, g_i, b_i};
    hs_d     = hsync_i;
    vs_d     = vsync_i;
    blank_d  = blank1_q;
  end

  // All control and pipeline flops clear asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en_q    <= 1'b0;
      pos_pend_x_q <= '0;
      pos_pend_y_q <= '0;
      pos_act_x_q  <= '0;
      pos_act_y_q  <= '0;
      pal1_q       <= '0;
      pal2_q       <= '0;
      vs_prev_q    <= 1'b0;
      hit1_q       <= 1'b0;
      addr1_q      <= '0;
      hit2_q       <= 1'b0;
      opq3_q       <= 1'b0;
      col3_q       <= '0;
      blank1_q     <= 1'b0;
      rgb_q        <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      blank_q      <= 1'b0;
    end else begin
      ctrl_en_q    <= ctrl_en_d;
      pos_pend_x_q <= pos_pend_x_d;
      pos_pend_y_q <= pos_pend_y_d;
      pos_act_x_q  <= pos_act_x_d;
      pos_act_y_q  <= pos_act_y_d;
      pal1_q       <= pal1_d;
      pal2_q       <= pal2_d;
      vs_prev_q    <= vs_prev_d;
      hit1_q       <= hit1_d;
      addr1_q      <= addr1_d;
      hit2_q       <= hit2_d;
      opq3_q       <= opq3_d;
      col3_q       <= col3_d;
      blank1_q     <= blank1_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blank_q      <= blank_d;
    end
  end

  // Sprite RAM: not reset; a colliding write returns the old word on read
  always_ff @(posedge clk) begin
    if (bus.spr_we) begin
      spr_mem[bus.spr_addr] <= bus.spr_wdata;
    end
    ram_rdata_q <= spr_mem[addr1_q];
  end

  assign {r_o, g_o, b_o} = rgb_q;
  assign hsync_o         = hs_q;
  assign vsync_o         = vs_q;
  assign blank_o         = blank_q;

endmodule

// File: tb/tb_dvga_sprite_ovl.sv
// Bench for dvga_sprite_ovl: a pixel-level model predicts every composited
// output from sprite position, RAM contents and palette; a negedge process
// compares each pixel four cycles after its coordinates were presented.
`ifndef XCNTW
`define XCNTW 11
`endif
`ifndef YCNTW
`define YCNTW 11
`endif

module tb_dvga_sprite_ovl;
  localparam int XW   = `XCNTW;
  localparam int YW   = `YCNTW;
  localparam int NMAX = 8192;

  logic clk = 1'b0;
  logic rst;
  logic [XW-1:0] xpos_i;
  logic [YW-1:0] ypos_i;
  logic [7:0] r_i, g_i, b_i, r_o, g_o, b_o;
  logic hsync_i, vsync_i, blank_i, hsync_o, vsync_o, blank_o;

  dvga_sprite_ovl_if bus ();

  dvga_sprite_ovl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .xpos_i  (xpos_i),
    .ypos_i  (ypos_i),
    .r_i     (r_i),
    .g_i     (g_i),
    .b_i     (b_i),
    .hsync_i (hsync_i),
    .vsync_i (vsync_i),
    .blank_i (blank_i),
    .r_o     (r_o),
    .g_o     (g_o),
    .b_o     (b_o),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .blank_o (blank_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Per-pixel stimulus log, indexed by the cycle its coordinates were driven
  int          px [NMAX];
  int          py [NMAX];
  logic [23:0] pc [NMAX];
  logic [23:0] pexp [NMAX];
  logic [23:0] plit [NMAX];
  bit          phaslit [NMAX];
  bit          pbl [NMAX];
  bit          pvs [NMAX];
  bit          phs [NMAX];
  int          n = 0;
  int          chk_from = 0;
  bit          chk_on = 1'b0;

  // Model state
  bit          m_en;
  int          m_ax, m_ay, m_px, m_py;
  logic [23:0] m_pal1, m_pal2;
  logic [1:0]  m_ram [256];
  bit          m_vs_prev;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s pix#%0d (x=%0d,y=%0d) got=%h want=%h", name, k,
               (k >= 0) ? px[k] : -1, (k >= 0) ? py[k] : -1, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0;
    m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
    m_pal1 = '0; m_pal2 = '0;
    m_vs_prev = 1'b0;
  endtask

  // Present one pixel for one clock; apply this cycle's writes to the model first
  task automatic pix(input int x, input int y, input bit bl, input bit vs, input bit hs,
                     input logic [23:0] c, input bit haslit, input logic [23:0] lit);
    bit hit;
    logic [1:0] idx;
    logic [23:0] pal;
    if (n >= NMAX) begin
      $display("FAIL stimulus log overflow at pixel %0d", n);
      $fatal(1);
    end
    if (bus.spr_we) m_ram[bus.spr_addr] = bus.spr_wdata;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        2'd0: m_en = bus.cfg_wdata[0];
        2'd1: begin
          m_px = int'(bus.cfg_wdata[XW-1:0]);
          m_py = int'(bus.cfg_wdata[16+YW-1:16]);
        end
        2'd2: m_pal1 = bus.cfg_wdata[23:0];
        default: m_pal2 = bus.cfg_wdata[23:0];
      endcase
    end
    if (vs && !m_vs_prev) begin
      m_ax = m_px;
      m_ay = m_py;
    end
    m_vs_prev = vs;
    hit = (x >= m_ax) && (x < m_ax + 16) && (y >= m_ay) && (y < m_ay + 16);
    idx = hit ? m_ram[(y - m_ay) * 16 + (x - m_ax)] : 2'd0;
    pal = (idx == 2'd1) ? m_pal1 : (idx == 2'd2) ? m_pal2 : 24'hFFFFFF;
    px[n] = x; py[n] = y; pc[n] = c; pbl[n] = bl; pvs[n] = vs; phs[n] = hs;
    pexp[n] = (m_en && hit && idx != 2'd0 && !bl) ? pal : c;
    phaslit[n] = haslit; plit[n] = lit;
    xpos_i  = x[XW-1:0];
    ypos_i  = y[YW-1:0];
    blank_i = (n >= 2) ? pbl[n-2] : 1'b0;
    if (n >= 3) begin
      {r_i, g_i, b_i} = pc[n-3];
      hsync_i = phs[n-3];
      vsync_i = pvs[n-3];
    end
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    bus.spr_we = 1'b0;
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) pix(0, 0, 1'b1, 1'b0, 1'b1, 24'h5A3C00 ^ 24'(n), 1'b0, 24'h0);
  endtask

  task automatic vis(input int x, input int y, input logic [23:0] c);
    pix(x, y, 1'b0, 1'b0, 1'b0, c, 1'b0, 24'h0);
  endtask

  task automatic visl(input int x, input int y, input logic [23:0] c, input logic [23:0] lit);
    pix(x, y, 1'b0, 1'b0, 1'b0, c, 1'b1, lit);
  endtask

  task automatic vsync_pulse();
    pix(0, 0, 1'b1, 1'b1, 1'b0, 24'h111111, 1'b0, 24'h0);
    pix(0, 0, 1'b1, 1'b1, 1'b0, 24'h222222, 1'b0, 24'h0);
    idle(5);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    idle(2);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    idle(3);
  endtask

  function automatic logic [31:0] pos_word(input int x, input int y);
    logic [31:0] w;
    w = '0;
    w[XW-1:0] = x[XW-1:0];
    w[16+YW-1:16] = y[YW-1:0];
    return w;
  endfunction

  task automatic load_ram(input logic [1:0] v, input int ha, input logic [1:0] hav,
                          input int hb, input logic [1:0] hbv);
    for (int i = 0; i < 256; i++) begin
      bus.spr_we = 1'b1;
      bus.spr_addr = 8'(i);
      bus.spr_wdata = (i == ha) ? hav : (i == hb) ? hbv : v;
      idle(1);
    end
    idle(2);
  endtask

  // Compare the pixel whose coordinates were driven four cycles ago
  always @(negedge clk) begin
    int k;
    k = n - 4;
    if (chk_on && k >= chk_from) begin
      chk("rgb", k, {8'h0, r_o, g_o, b_o}, {8'h0, pexp[k]});
      chk("hsync", k, {31'h0, hsync_o}, {31'h0, phs[k]});
      chk("vsync", k, {31'h0, vsync_o}, {31'h0, pvs[k]});
      chk("blank", k, {31'h0, blank_o}, {31'h0, pbl[k]});
      if (phaslit[k]) chk("literal", k, {8'h0, r_o, g_o, b_o}, {8'h0, plit[k]});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at pixel %0d", n);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.spr_we = 1'b0; bus.spr_addr = '0; bus.spr_wdata = '0;
    xpos_i = '0; ypos_i = '0;
    {r_i, g_i, b_i} = 24'hFFFFFF;
    hsync_i = 1'b1; vsync_i = 1'b1; blank_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rgb", -1, {8'h0, r_o, g_o, b_o}, 32'h0);
    chk("reset_hsync", -1, {31'h0, hsync_o}, 32'h0);
    chk("reset_vsync", -1, {31'h0, vsync_o}, 32'h0);
    chk("reset_blank", -1, {31'h0, blank_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk_on = 1'b1;

    // Disabled: pure pass-through with syncs and blank
    idle(4);
    for (int i = 0; i < 6; i++) vis(10 + i, 10, {8'h40, 8'(i), 8'h22});
    visl(10, 10, 24'h401122, 24'h401122);
    pix(12, 10, 1'b1, 1'b0, 1'b1, 24'h404040, 1'b1, 24'h404040);
    vsync_pulse();

    // Red sprite at (100,50); position only moves on vsync rise
    load_ram(2'd1, -1, 2'd0, -1, 2'd0);
    cfg_write(2'd2, 32'h00FF0000);
    cfg_write(2'd1, pos_word(100, 50));
    cfg_write(2'd0, 32'h1);
    visl(100, 50, 24'h123456, 24'h123456);
    visl(3, 3, 24'h123456, 24'hFF0000);
    vsync_pulse();
    for (int r = 0; r < 4; r++) begin
      for (int x = 98; x <= 117; x++) vis(x, (r == 0) ? 49 : (r == 1) ? 50 : (r == 2) ? 65 : 66,
                                          {8'h40, 8'(x), 8'(r)});
      idle(2);
    end
    visl(99, 50, 24'h0A0B0C, 24'h0A0B0C);
    visl(100, 50, 24'h0A0B0C, 24'hFF0000);
    visl(115, 65, 24'h0A0B0C, 24'hFF0000);
    visl(116, 50, 24'h0A0B0C, 24'h0A0B0C);
    visl(100, 66, 24'h0A0B0C, 24'h0A0B0C);
    visl(100, 49, 24'h0A0B0C, 24'h0A0B0C);

    // Mid-frame position write stays pending until the next vsync rise
    vis(105, 52, 24'h333333);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_wdata = pos_word(200, 0);
    vis(106, 52, 24'h333333);
    for (int i = 0; i < 6; i++) vis(104 + i, 53, 24'h444444);
    visl(100, 50, 24'h555555, 24'hFF0000);
    visl(200, 0, 24'h555555, 24'h555555);
    vsync_pulse();
    visl(200, 0, 24'h555555, 24'hFF0000);
    visl(100, 50, 24'h555555, 24'h555555);

    // Transparent hole at {3,5}, white at {0,0}, green elsewhere
    cfg_write(2'd3, 32'h0000FF00);
    load_ram(2'd2, 8'h35, 2'd0, 8'h00, 2'd3);
    visl(205, 3, 24'h606060, 24'h606060);
    visl(204, 3, 24'h606060, 24'h00FF00);
    visl(206, 3, 24'h606060, 24'h00FF00);
    visl(205, 2, 24'h606060, 24'h00FF00);
    visl(205, 4, 24'h606060, 24'h00FF00);
    visl(200, 0, 24'h606060, 24'hFFFFFF);

    // RAM write colliding with the read of the same entry returns old data
    visl(200, 1, 24'h707070, 24'h00FF00);
    bus.spr_we = 1'b1; bus.spr_addr = 8'h10; bus.spr_wdata = 2'd0;
    vis(300, 300, 24'h717171);
    idle(1);
    visl(200, 1, 24'h727272, 24'h727272);

    // Simultaneous register and RAM writes both land
    idle(2);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_wdata = 32'h000000FF;
    bus.spr_we = 1'b1; bus.spr_addr = 8'h11; bus.spr_wdata = 2'd1;
    idle(3);
    visl(201, 1, 24'h808080, 24'h0000FF);

    // Right-edge clipping: only columns 2040..2047 drawn, no wrap to x=0
    cfg_write(2'd1, pos_word((1 << XW) - 8, 0));
    vsync_pulse();
    for (int x = (1 << XW) - 12; x < (1 << XW); x++) vis(x, 0, {8'h90, 8'(x), 8'h01});
    for (int x = 0; x < 10; x++) vis(x, 0, {8'h90, 8'(x), 8'h02});
    idle(2);
    visl((1 << XW) - 8, 0, 24'h909090, 24'hFFFFFF);
    visl((1 << XW) - 1, 0, 24'h909090, 24'h00FF00);
    visl((1 << XW) - 9, 0, 24'h909090, 24'h909090);
    visl(0, 0, 24'h909090, 24'h909090);
    visl(7, 0, 24'h909090, 24'h909090);

    // Bottom-edge clipping
    cfg_write(2'd1, pos_word(300, (1 << YW) - 4));
    vsync_pulse();
    visl(300, (1 << YW) - 1, 24'hA0A0A0, 24'h00FF00);
    visl(305, (1 << YW) - 1, 24'hA0A0A0, 24'hA0A0A0);
    visl(300, 0, 24'hA0A0A0, 24'hA0A0A0);
    visl(300, 3, 24'hA0A0A0, 24'hA0A0A0);
    cfg_write(2'd0, 32'h0);
    visl(300, (1 << YW) - 4, 24'hA1A1A1, 24'hA1A1A1);
    cfg_write(2'd0, 32'h1);
    for (int x = 298; x < 306; x++) vis(x, (1 << YW) - 3, 24'hB0B0B0);

    // Asynchronous mid-line reset: outputs clear at once, config returns to zero
    chk_on = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rgb", -1, {8'h0, r_o, g_o, b_o}, 32'h0);
    chk("midrst_hsync", -1, {31'h0, hsync_o}, 32'h0);
    chk("midrst_vsync", -1, {31'h0, vsync_o}, 32'h0);
    chk("midrst_blank", -1, {31'h0, blank_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk_from = n;
    chk_on = 1'b1;
    visl(300, (1 << YW) - 4, 24'hC0C0C0, 24'hC0C0C0);
    visl(5, 5, 24'hC1C1C1, 24'hC1C1C1);
    cfg_write(2'd0, 32'h1);
    visl(5, 5, 24'hC2C2C2, 24'h000000);
    visl(0, 0, 24'hC3C3C3, 24'hFFFFFF);
    visl(16, 0, 24'hC4C4C4, 24'hC4C4C4);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
